// File: rtl/mem_ctrl_arb.sv
// Byte-serial RAM controller arbitrating the i-cache fetch port and the MEM-stage load/store port
// onto an 8-bit RAM/IO bus with a parametrised, pipelined read latency.
module mem_ctrl_arb #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifetch_req,
  input  logic [ADDR_W-1:0] ifetch_addr,
  input  logic              ifetch_flush,
  output logic              ifetch_valid,
  output logic [31:0]       ifetch_data,
  input  logic              data_load,
  input  logic              data_store,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  input  logic [2:0]        data_len,
  input  logic              data_signed,
  output logic              data_done,
  output logic [31:0]       data_rdata,
  input  logic [7:0]        mem_din,
  input  logic              io_buffer_full,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_DRAIN, S_WR, S_FLUSH_DRAIN
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [1:0]        r_last;
  logic [1:0]        r_cnt;
  logic [31:0]       r_wdata;
  logic [31:0]       r_result;
  logic              r_signed;
  logic              r_is_fetch;
  logic [RD_LAT-1:0] r_pipe_v;
  logic [1:0]        r_pipe_idx [RD_LAT];
  logic              r_ifetch_valid;
  logic              r_data_done;
  logic [31:0]       r_ifetch_data;
  logic [31:0]       r_data_rdata;

  logic        w_flush;
  logic        w_issue;
  logic        w_cap;
  logic [1:0]  w_cap_idx;
  logic        w_cap_last;
  logic [31:0] w_word;
  logic [31:0] w_ext;

  // Last byte index: lengths other than 1 and 2 behave as a full word.
  function automatic logic [1:0] len_to_last(input logic [2:0] len);
    case (len)
      3'd1:    return 2'd0;
      3'd2:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  assign w_flush    = r_is_fetch && ifetch_flush &&
                      (r_state == S_RD_ISSUE || r_state == S_RD_DRAIN);
  assign w_issue    = (r_state == S_RD_ISSUE) && !w_flush;
  assign w_cap      = r_pipe_v[RD_LAT-1];
  assign w_cap_idx  = r_pipe_idx[RD_LAT-1];
  assign w_cap_last = w_cap && (w_cap_idx == r_last) && (r_state == S_RD_DRAIN);

  // Result word with the byte arriving this cycle already merged in.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cap
    assign w_word[8*gi +: 8] = (w_cap && w_cap_idx == 2'(gi)) ? mem_din : r_result[8*gi +: 8];
  end

  always_comb begin
    w_ext = w_word;
    case (r_last)
      2'd0:    w_ext = {{24{r_signed & w_word[7]}}, w_word[7:0]};
      2'd1:    w_ext = {{16{r_signed & w_word[15]}}, w_word[15:0]};
      default: w_ext = w_word;
    endcase
  end

  assign mem_a    = (r_state == S_RD_ISSUE || r_state == S_WR) ? r_base + ADDR_W'(r_cnt) : '0;
  assign mem_dout = (r_state == S_WR) ? r_wdata[{r_cnt, 3'b000} +: 8] : 8'd0;
  assign mem_wr   = (r_state == S_WR) && !io_buffer_full;
  assign busy     = (r_state != S_IDLE);

  assign ifetch_valid = r_ifetch_valid;
  assign ifetch_data  = r_ifetch_data;
  assign data_done    = r_data_done;
  assign data_rdata   = r_data_rdata;

  // Each issued read is tagged with its byte index and surfaces RD_LAT cycles later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pipe_v <= '0;
      for (int k = 0; k < RD_LAT; k++) r_pipe_idx[k] <= 2'd0;
    end else begin
      r_pipe_v[0]   <= w_issue;
      r_pipe_idx[0] <= r_cnt;
      for (int k = 1; k < RD_LAT; k++) begin
        r_pipe_v[k]   <= r_pipe_v[k-1];
        r_pipe_idx[k] <= r_pipe_idx[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_base         <= '0;
      r_last         <= 2'd0;
      r_cnt          <= 2'd0;
      r_wdata        <= 32'd0;
      r_result       <= 32'd0;
      r_signed       <= 1'b0;
      r_is_fetch     <= 1'b0;
      r_ifetch_valid <= 1'b0;
      r_data_done    <= 1'b0;
      r_ifetch_data  <= 32'd0;
      r_data_rdata   <= 32'd0;
    end else begin
      r_ifetch_valid <= 1'b0;
      r_data_done    <= 1'b0;
      if (w_cap) r_result <= w_word;
      case (r_state)
        S_IDLE: begin
          // Requesters are still dropping their request during a completion pulse.
          if (!r_ifetch_valid && !r_data_done) begin
            r_cnt    <= 2'd0;
            r_result <= 32'd0;
            if (data_store) begin
              r_base     <= data_addr;
              r_last     <= len_to_last(data_len);
              r_wdata    <= data_wdata;
              r_signed   <= data_signed;
              r_is_fetch <= 1'b0;
              r_state    <= S_WR;
            end else if (data_load) begin
              r_base     <= data_addr;
              r_last     <= len_to_last(data_len);
              r_wdata    <= data_wdata;
              r_signed   <= data_signed;
              r_is_fetch <= 1'b0;
              r_state    <= S_RD_ISSUE;
            end else if (ifetch_req && !ifetch_flush) begin
              r_base     <= ifetch_addr;
              r_last     <= 2'd3;
              r_signed   <= 1'b0;
              r_is_fetch <= 1'b1;
              r_state    <= S_RD_ISSUE;
            end
          end
        end
        S_RD_ISSUE: begin
          if (w_flush)              r_state <= S_FLUSH_DRAIN;
          else if (r_cnt == r_last) r_state <= S_RD_DRAIN;
          else                      r_cnt   <= r_cnt + 2'd1;
        end
        S_RD_DRAIN: begin
          if (w_flush) begin
            r_state <= S_FLUSH_DRAIN;
          end else if (w_cap_last) begin
            r_state <= S_IDLE;
            if (r_is_fetch) begin
              r_ifetch_valid <= 1'b1;
              r_ifetch_data  <= w_word;
            end else begin
              r_data_done  <= 1'b1;
              r_data_rdata <= w_ext;
            end
          end
        end
        S_WR: begin
          if (!io_buffer_full) begin
            if (r_cnt == r_last) begin
              r_state     <= S_IDLE;
              r_data_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        S_FLUSH_DRAIN: begin
          if (r_pipe_v == '0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Scoreboard bench for mem_ctrl_arb: three independent environments (RD_LAT = 1, 2, 3) each run
// directed scenarios and random fetch/load/store traffic against a byte-level memory model.
module tb_mem_ctrl_arb;
  logic clk;
  int n_checks = 0;
  int n_fail = 0;
  int envs_finished = 0;

  typedef struct { int acc; logic [31:0] val; int n; bit st; } exp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E3779B1;
    return h[31:24];
  endfunction

  task automatic chk(input int env, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL env%0d %s: got 0x%08h expected 0x%08h", env, name, act, exp);
    end
  endtask

  task automatic fail_now(input int env, input string name);
    n_checks++;
    n_fail++;
    $display("FAIL env%0d %s", env, name);
  endtask

  task automatic env_finish();
    envs_finished++;
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_env
    localparam int LAT = gi + 1;
    logic        rst, ifetch_req, ifetch_flush, ifetch_valid, data_load, data_store, data_signed;
    logic        data_done, io_full, mem_wr, busy;
    logic [31:0] ifetch_addr, ifetch_data, data_addr, data_wdata, data_rdata, mem_a;
    logic [2:0]  data_len;
    logic [7:0]  mem_din, mem_dout;
    int          cyc = 0;
    bit          iof_rand = 0;
    logic [7:0]  ref_mem [logic [31:0]];
    logic [7:0]  bus_mem [logic [31:0]];
    bit          iof_hist [int];
    exp_t        dq[$];
    exp_t        fq[$];
    wr_t         wq[$];
    logic [7:0]  d_pipe [LAT];

    mem_ctrl_arb #(.ADDR_W(32), .RD_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_flush(ifetch_flush),
      .ifetch_valid(ifetch_valid), .ifetch_data(ifetch_data),
      .data_load(data_load), .data_store(data_store), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_len(data_len), .data_signed(data_signed),
      .data_done(data_done), .data_rdata(data_rdata),
      .mem_din(mem_din), .io_buffer_full(io_full), .mem_dout(mem_dout),
      .mem_a(mem_a), .mem_wr(mem_wr), .busy(busy)
    );

    function automatic logic [7:0] bus_rd(input logic [31:0] a);
      if (bus_mem.exists(a)) return bus_mem[a];
      return init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_byte(a);
    endfunction

    function automatic int len_n(input logic [2:0] len);
      if (len == 3'd1) return 1;
      if (len == 3'd2) return 2;
      return 4;
    endfunction

    // Little-endian assembly of n bytes, then sign or zero fill above 8n bits.
    function automatic logic [31:0] ref_value(input logic [31:0] a, input int n, input bit sgn);
      logic [31:0] v;
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_rd(a + 32'(i))) << (8 * i));
      if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      return v;
    endfunction

    // RAM returns the byte addressed in cycle C during cycle C+LAT.
    always @(posedge clk) begin
      cyc <= cyc + 1;
      d_pipe[0] <= bus_rd(mem_a);
      for (int k = 1; k < LAT; k++) d_pipe[k] <= d_pipe[k-1];
    end
    assign mem_din = d_pipe[LAT-1];

    initial forever begin
      @(posedge clk);
      #1;
      if (iof_rand) io_full = ($urandom_range(0, 3) == 0);
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic set_mem(input logic [31:0] a, input logic [7:0] d);
      ref_mem[a] = d;
      bus_mem[a] = d;
    endtask

    task automatic start_load(input logic [31:0] a, input logic [2:0] len, input bit sgn);
      exp_t e;
      e.acc = cyc; e.n = len_n(len); e.val = ref_value(a, e.n, sgn); e.st = 0;
      dq.push_back(e);
      data_addr = a; data_len = len; data_signed = sgn; data_load = 1;
    endtask

    task automatic start_store(input logic [31:0] a, input logic [2:0] len, input logic [31:0] w);
      exp_t e;
      wr_t x;
      e.acc = cyc; e.n = len_n(len); e.val = 32'd0; e.st = 1;
      for (int i = 0; i < e.n; i++) begin
        x.a = a + 32'(i);
        x.d = w[8*i +: 8];
        wq.push_back(x);
        ref_mem[x.a] = x.d;
      end
      dq.push_back(e);
      data_addr = a; data_len = len; data_wdata = w; data_signed = 1'($urandom_range(0, 1));
      data_store = 1;
    endtask

    task automatic start_fetch(input logic [31:0] a);
      exp_t e;
      e.acc = cyc; e.n = 4; e.val = ref_value(a, 4, 0); e.st = 0;
      fq.push_back(e);
      ifetch_addr = a; ifetch_req = 1;
    endtask

    task automatic wait_data();
      int k;
      for (k = 0; k < 400; k++) begin
        tick();
        if (data_done) break;
      end
      if (k == 400) begin
        fail_now(gi, "data_done timeout");
        dq.delete();
      end
      data_load = 0; data_store = 0;
    endtask

    task automatic wait_fetch();
      int k;
      for (k = 0; k < 400; k++) begin
        tick();
        if (ifetch_valid) break;
      end
      if (k == 400) begin
        fail_now(gi, "ifetch_valid timeout");
        fq.delete();
      end
      ifetch_req = 0;
    endtask

    task automatic chk_idle_outputs(input string tag);
      chk(gi, {tag, " busy"}, {31'd0, busy}, 32'd0);
      chk(gi, {tag, " mem_a"}, mem_a, 32'd0);
      chk(gi, {tag, " mem_wr"}, {31'd0, mem_wr}, 32'd0);
      chk(gi, {tag, " mem_dout"}, {24'd0, mem_dout}, 32'd0);
      chk(gi, {tag, " done"}, {31'd0, data_done}, 32'd0);
      chk(gi, {tag, " valid"}, {31'd0, ifetch_valid}, 32'd0);
    endtask

    // Monitor: bus writes and completion pulses are compared against the scoreboard queues.
    initial forever begin
      exp_t e;
      wr_t  x;
      int   c, k;
      @(negedge clk);
      iof_hist[cyc] = io_full;
      if (mem_wr) begin
        chk(gi, "write while io full", {31'd0, io_full}, 32'd0);
        if (wq.size() == 0) fail_now(gi, "unexpected write");
        else begin
          x = wq.pop_front();
          chk(gi, "write addr", mem_a, x.a);
          chk(gi, "write byte", {24'd0, mem_dout}, {24'd0, x.d});
        end
        bus_mem[mem_a] = mem_dout;
      end
      if (data_done && ifetch_valid) fail_now(gi, "done and valid together");
      if (data_done) begin
        if (dq.size() == 0) fail_now(gi, "unexpected data_done");
        else begin
          e = dq.pop_front();
          if (e.st) begin
            c = e.acc + 1; k = 0;
            while (k < e.n && c < e.acc + 2000) begin
              if (!(iof_hist.exists(c) && iof_hist[c])) k++;
              c++;
            end
            chk(gi, "store done cycle", 32'(cyc), 32'(c));
            chk(gi, "store writes left", 32'(wq.size()), 32'd0);
            $display("env%0d store n=%0d accepted %0d done %0d", gi, e.n, e.acc, cyc);
          end else begin
            chk(gi, "load done cycle", 32'(cyc), 32'(e.acc + e.n + LAT + 1));
            chk(gi, "load data", data_rdata, e.val);
            $display("env%0d load n=%0d accepted %0d done %0d data 0x%08h", gi, e.n, e.acc, cyc, data_rdata);
          end
        end
      end
      if (ifetch_valid) begin
        if (fq.size() == 0) fail_now(gi, "unexpected ifetch_valid");
        else begin
          e = fq.pop_front();
          chk(gi, "fetch valid cycle", 32'(cyc), 32'(e.acc + 4 + LAT + 1));
          chk(gi, "fetch data", ifetch_data, e.val);
          $display("env%0d fetch accepted %0d valid %0d data 0x%08h", gi, e.acc, cyc, ifetch_data);
        end
      end
    end

    initial begin
      int t, k, kind;
      logic [31:0] a;
      exp_t e;
      rst = 0; ifetch_req = 0; ifetch_addr = 0; ifetch_flush = 0;
      data_load = 0; data_store = 0; data_addr = 0; data_wdata = 0; data_len = 0; data_signed = 0;
      io_full = 0;
      tick(); tick();
      chk_idle_outputs("reset");
      rst = 1;
      tick();
      set_mem(32'h100, 8'h13); set_mem(32'h101, 8'h05); set_mem(32'h102, 8'h00); set_mem(32'h103, 8'h00);
      set_mem(32'h200, 8'h80); set_mem(32'h210, 8'h34); set_mem(32'h211, 8'h92);

      start_fetch(32'h100); wait_fetch();
      chk(gi, "T1 fetch word", ifetch_data, 32'h00000513);
      tick(); start_load(32'h200, 3'd1, 1); wait_data();
      chk(gi, "T2 lb signed", data_rdata, 32'hFFFFFF80);
      tick(); start_load(32'h200, 3'd1, 0); wait_data();
      chk(gi, "T2 lb unsigned", data_rdata, 32'h00000080);
      tick(); start_load(32'h210, 3'd2, 1); wait_data();
      chk(gi, "T2 lh signed", data_rdata, 32'hFFFF9234);

      tick(); t = cyc;
      start_store(32'h30000, 3'd4, 32'hDEADBEEF);
      tick(); tick(); tick();
      io_full = 1;
      tick(); tick(); tick();
      io_full = 0;
      wait_data();
      chk(gi, "T3 store done cycle", 32'(cyc), 32'(t + 8));
      tick(); start_load(32'h30000, 3'd4, 0); wait_data();
      chk(gi, "T3 readback", data_rdata, 32'hDEADBEEF);

      tick(); t = cyc;
      start_store(32'h400, 3'd2, $urandom);
      start_fetch(32'h100);
      wait_data();
      chk(gi, "T4 store first", 32'(cyc), 32'(t + 3));
      if (fq.size() > 0) begin
        e = fq.pop_front();
        e.acc = cyc + 1;
        fq.push_front(e);
      end
      wait_fetch();
      chk(gi, "T4 fetch word", ifetch_data, 32'h00000513);

      tick(); ifetch_addr = 32'h100; ifetch_req = 1; ifetch_flush = 1;
      tick(); ifetch_req = 0; ifetch_flush = 0;
      chk(gi, "fetch with flush ignored", {31'd0, busy}, 32'd0);

      tick(); ifetch_addr = 32'h104; ifetch_req = 1;
      tick(); tick();
      ifetch_flush = 1; ifetch_req = 0;
      tick(); ifetch_flush = 0;
      for (k = 0; k < 12; k++) begin
        if (!busy) break;
        tick();
      end
      chk(gi, "T5 busy after flush drain", {31'd0, busy}, 32'd0);
      tick(); start_fetch(32'h100); wait_fetch();
      chk(gi, "T5 fetch after flush", ifetch_data, 32'h00000513);
      tick(); start_load(32'h210, 3'd2, 0); ifetch_flush = 1; wait_data(); ifetch_flush = 0;
      chk(gi, "flush during load", data_rdata, 32'h00009234);

      tick(); start_load(32'h100, 3'd4, 0);
      tick(); tick(); tick();
      rst = 0;
      #1;
      chk_idle_outputs("T6 reset");
      dq.delete(); data_load = 0;
      tick(); tick();
      rst = 1;
      tick();
      start_load(32'h210, 3'd2, 1); wait_data();
      chk(gi, "T6 load after reset", data_rdata, 32'hFFFF9234);

      iof_rand = 1;
      for (int it = 0; it < 40; it++) begin
        repeat ($urandom_range(1, 2)) tick();
        if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFD + 32'($urandom_range(0, 2));
        else a = 32'h1000 + 32'($urandom_range(0, 63));
        kind = $urandom_range(0, 2);
        if (kind == 0) begin
          start_fetch(a); wait_fetch();
        end else if (kind == 1) begin
          start_load(a, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))); wait_data();
        end else begin
          start_store(a, 3'($urandom_range(0, 7)), $urandom); wait_data();
        end
      end
      iof_rand = 0;
      io_full = 0;
      tick(); tick(); tick();
      env_finish();
    end
  end

  initial begin
    int k;
    for (k = 0; k < 60000; k++) begin
      @(posedge clk);
      if (envs_finished == 3) break;
    end
    if (envs_finished != 3) begin
      n_checks++;
      n_fail++;
      $display("FAIL global timeout: %0d of 3 environments finished", envs_finished);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
